// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus plus the register-file write port.
// master: writeback sources / register-file side; slave: the arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][4:0]  req_reg;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     write_enable;
    logic [4:0]               write_reg;
    logic [31:0]              write_data;

    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, write_enable, write_reg, write_data
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, write_enable, write_reg, write_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_REQ writeback sources. The granted write is registered before it
// reaches the register file. Optional destination-register scoreboard
// (busy_mask / stall) is built only when REGFILE_ARB_SCOREBOARD_EN is defined;
// otherwise busy_mask_o and stall_o are tied to 0.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus,
    input  logic                   reserve_valid_i,
    input  logic [4:0]             reserve_reg_i,
    input  logic [4:0]             read_index1_i,
    input  logic [4:0]             read_index2_i,
    output logic                   stall_o,
    output logic [31:0]            busy_mask_o
);
    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_idx;
    logic               grant_vld;
    logic [NUM_REQ-1:0] req_ready;
    logic               we_q, we_d;
    logic [4:0]         wreg_q, wreg_d;
    logic [31:0]        wdata_q, wdata_d;

    // Round-robin pick: scan from last_grant+1 with wrap, first valid wins
    always_comb begin
        int          idx;
        logic [GW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        // no handshake can complete while reset is held
        if (rst) grant_vld = 1'b0;
    end

    // One-hot ready for the winner
    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    assign bus.req_ready = req_ready;

    // Next write-port contents; writes to r0 are consumed but never strobed
    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        if (grant_vld) begin
            last_grant_d = grant_idx;
            if (bus.req_reg[grant_idx] != 5'd0) begin
                we_d    = 1'b1;
                wreg_d  = bus.req_reg[grant_idx];
                wdata_d = bus.req_data[grant_idx];
            end
        end
    end

    // Write-port register and arbitration pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GW'(NUM_REQ - 1);
            we_q         <= 1'b0;
            wreg_q       <= 5'd0;
            wdata_q      <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.write_enable = we_q;
    assign bus.write_reg    = wreg_q;
    assign bus.write_data   = wdata_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Clear on the register-file write, then set on reservation (set wins)
    always_comb begin
        busy_d = busy_q;
        if (we_q) busy_d[wreg_q] = 1'b0;
        if (reserve_valid_i && reserve_reg_i != 5'd0) busy_d[reserve_reg_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Scoreboard storage; reset drops every reservation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= 32'd0;
        else     busy_q <= busy_d;
    end

    assign busy_mask_o = busy_q;
    assign stall_o     = (read_index1_i != 5'd0 && busy_q[read_index1_i]) ||
                         (read_index2_i != 5'd0 && busy_q[read_index2_i]);
`else
    logic unused_sb;
    assign unused_sb   = ^{reserve_valid_i, reserve_reg_i, read_index1_i, read_index2_i};
    assign busy_mask_o = 32'd0;
    assign stall_o     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: random and directed writeback
// traffic, reservations and read indices checked against a reference model.
module tb_regfile_write_arbiter;
    localparam int NR = 3;
`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reserve_valid = 1'b0;
    logic [4:0]  reserve_reg = '0, read_index1 = '0, read_index2 = '0;
    logic        stall;
    logic [31:0] busy_mask;

    regfile_write_arbiter_if #(.NUM_REQ(NR)) bus ();

    regfile_write_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .reserve_valid_i(reserve_valid), .reserve_reg_i(reserve_reg),
        .read_index1_i(read_index1), .read_index2_i(read_index2),
        .stall_o(stall), .busy_mask_o(busy_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct { int cyc; logic [4:0] r; logic [31:0] d; } wr_t;
    wr_t expq[$];

    // requester state held by the bench until transfer
    logic [NR-1:0]       hv = '0;
    logic [NR-1:0][4:0]  hreg = '0;
    logic [NR-1:0][31:0] hdata = '0;
    logic                res_v = 1'b0;
    logic [4:0]          res_r = '0, ri1 = '0, ri2 = '0;

    // reference model state
    int          last_m = NR - 1;
    logic [31:0] busy_m = '0;
    logic        cur_we = 1'b0;
    logic [4:0]  cur_reg = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every non-reset cycle the write port must match the queue head
    always @(negedge clk) begin
        logic exp_we;
        if (!rst) begin
            exp_we = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("write_enable", {63'd0, bus.write_enable}, {63'd0, exp_we});
            if (exp_we) begin
                chk("write_reg", {59'd0, bus.write_reg}, {59'd0, expq[0].r});
                chk("write_data", {32'd0, bus.write_data}, {32'd0, expq[0].d});
                void'(expq.pop_front());
            end
        end
    end

    function automatic logic [31:0] exp_mask();
        return SB ? busy_m : 32'd0;
    endfunction

    // One cycle: drive, predict grant/busy/stall, advance model at the edge
    task automatic step();
        int          g;
        int          c;
        logic [31:0] nb, eb;
        logic [NR-1:0] exp_rdy;
        logic        nxt_we;
        logic [4:0]  nxt_reg;
        bus.req_valid = hv; bus.req_reg = hreg; bus.req_data = hdata;
        reserve_valid = res_v; reserve_reg = res_r;
        read_index1 = ri1; read_index2 = ri2;
        #1;
        g = -1;
        for (int k = 1; k <= NR; k++) begin
            c = (last_m + k) % NR;
            if (g < 0 && hv[c]) g = c;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", {61'd0, bus.req_ready}, {61'd0, exp_rdy});
        eb = exp_mask();
        chk("busy_mask", {32'd0, busy_mask}, {32'd0, eb});
        chk("stall", {63'd0, stall},
            {63'd0, (ri1 != 0 && eb[ri1]) || (ri2 != 0 && eb[ri2])});
        nb = busy_m;
        if (cur_we) nb[cur_reg] = 1'b0;
        if (res_v && res_r != 0) nb[res_r] = 1'b1;
        nxt_we = 1'b0; nxt_reg = cur_reg;
        if (g >= 0) begin
            last_m = g;
            if (hreg[g] != 0) begin
                nxt_we = 1'b1; nxt_reg = hreg[g];
                expq.push_back('{cyc + 1, hreg[g], hdata[g]});
            end
            hv[g] = 1'b0;
        end
        @(posedge clk); #1;
        busy_m = nb; cur_we = nxt_we; cur_reg = nxt_reg;
    endtask

    task automatic refill(input int pct, input bit allow0);
        for (int i = 0; i < NR; i++)
            if (!hv[i] && $urandom_range(99) < pct) begin
                hv[i]    = 1'b1;
                hreg[i]  = allow0 ? 5'($urandom_range(31, 0)) : 5'($urandom_range(31, 1));
                hdata[i] = $urandom;
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // reset state with requests and reservations pending on the inputs
        bus.req_valid = '1; bus.req_reg = '1; bus.req_data = '1;
        reserve_valid = 1'b1; reserve_reg = 5'd3; read_index1 = 5'd3; read_index2 = 5'd3;
        #2;
        chk("rst_req_ready", {61'd0, bus.req_ready}, 64'd0);
        chk("rst_write_enable", {63'd0, bus.write_enable}, 64'd0);
        chk("rst_write_reg", {59'd0, bus.write_reg}, 64'd0);
        chk("rst_write_data", {32'd0, bus.write_data}, 64'd0);
        chk("rst_busy_mask", {32'd0, busy_mask}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single request from requester 1
        hv[1] = 1'b1; hreg[1] = 5'd5; hdata[1] = 32'hDEADBEEF;
        step(); step(); step();

        // write to r0 is consumed without a strobe
        hv[2] = 1'b1; hreg[2] = 5'd0; hdata[2] = 32'h1234;
        step(); step();

        // all three continuously valid: grants rotate 0,1,2,...
        refill(100, 1'b0);
        for (int i = 0; i < 6; i++) begin refill(100, 1'b0); step(); end
        step(); step();

        // reserve r7, read it, then write it back through requester 0
        res_v = 1'b1; res_r = 5'd7; ri1 = 5'd7; ri2 = 5'd0;
        step();
        res_v = 1'b0;
        step(); step();
        hv[0] = 1'b1; hreg[0] = 5'd7; hdata[0] = 32'hA5A5_0007;
        step(); step(); step(); step();

        // same-edge set and clear of r9
        hv[0] = 1'b1; hreg[0] = 5'd9; hdata[0] = 32'h0000_0009; ri1 = 5'd9;
        step();
        res_v = 1'b1; res_r = 5'd9;
        step();
        res_v = 1'b0;
        step(); step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            refill(40, 1'b1);
            res_v = ($urandom_range(3) == 0);
            res_r = 5'($urandom_range(31, 0));
            ri1   = 5'($urandom_range(31, 0));
            ri2   = 5'($urandom_range(31, 0));
            step();
        end
        hv = '0; res_v = 1'b0;
        step(); step();

        // async reset with a write in flight and r7 busy
        hv[1] = 1'b1; hreg[1] = 5'd8; hdata[1] = 32'hCAFE_0008;
        res_v = 1'b1; res_r = 5'd7;
        step();
        res_v = 1'b0; ri1 = 5'd7; ri2 = 5'd0; hv = '1;
        bus.req_valid = hv; reserve_valid = 1'b0; read_index1 = ri1; read_index2 = ri2;
        #1;
        chk("pre_rst_write_enable", {63'd0, bus.write_enable}, {63'd0, cur_we});
        chk("pre_rst_busy_mask", {32'd0, busy_mask}, {32'd0, exp_mask()});
        chk("pre_rst_stall", {63'd0, stall}, {63'd0, exp_mask() != 0});
        rst = 1'b1;
        #1;
        chk("midrst_write_enable", {63'd0, bus.write_enable}, 64'd0);
        chk("midrst_busy_mask", {32'd0, busy_mask}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        chk("midrst_req_ready", {61'd0, bus.req_ready}, 64'd0);
        expq.delete();
        busy_m = '0; last_m = NR - 1; cur_we = 1'b0; hv = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        // first post-reset grant goes to requester 0
        for (int i = 0; i < 4; i++) begin refill(100, 1'b0); step(); end
        hv = '0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
